// File: rtl/ast_pkg.sv
// rtl/ast_pkg.sv - shared types and width helpers for the Avalon-ST word sender/receiver pair
package ast_pkg;

    typedef enum logic [1:0] {
        AST_RX_IDLE    = 2'd0,
        AST_RX_COLLECT = 2'd1,
        AST_RX_HOLD    = 2'd2
    } ast_rx_state_t;

    // A single-symbol beat still carries a 1-bit empty field.
    function automatic int ast_empty_w(input int symbols);
        return (symbols == 1) ? 1 : $clog2(symbols);
    endfunction

    function automatic int ast_len_w(input int symbols);
        return $clog2(symbols + 1);
    endfunction

endpackage

// File: rtl/ast_to_data.sv
// rtl/ast_to_data.sv - Avalon-ST sink that assembles one packet into a single output word
module ast_to_data
    import ast_pkg::*;
#(
    parameter int BYTE_W           = 8,
    parameter int DATA_SYMBOLS     = 6,
    parameter int AST_SINK_SYMBOLS = 1,
    parameter bit AST_SINK_ORDER   = 1'b1,
    parameter int AST_SINK_EMPTY_W = ast_empty_w(AST_SINK_SYMBOLS)
) (
    input  logic                                 clk_i,
    input  logic                                 srst_i,
    input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0]   ast_sink_data_i,
    input  logic                                 ast_sink_valid_i,
    output logic                                 ast_sink_ready_o,
    input  logic [AST_SINK_EMPTY_W-1:0]          ast_sink_empty_i,
    input  logic                                 ast_sink_startofpacket_i,
    input  logic                                 ast_sink_endofpacket_i,
    output logic [DATA_SYMBOLS*BYTE_W-1:0]       data_o,
    output logic [ast_len_w(DATA_SYMBOLS)-1:0]   data_len_o,
    output logic                                 data_err_o,
    output logic                                 data_valid_o,
    input  logic                                 data_ready_i
);

    localparam int LEN_W  = ast_len_w(DATA_SYMBOLS);
    localparam int WORD_W = DATA_SYMBOLS * BYTE_W;

    ast_rx_state_t     state_q;
    logic [WORD_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic              valid_q;
    logic              ready_q;
    logic              accept;

    logic [BYTE_W-1:0] beat_sym [AST_SINK_SYMBOLS];
    int                base;
    int                nsym;
    int                total;

    // beat_sym[k] is the k-th symbol of the beat in arrival order.
    always_comb begin
        for (int k = 0; k < AST_SINK_SYMBOLS; k++) begin
            beat_sym[k] = AST_SINK_ORDER ? ast_sink_data_i[(AST_SINK_SYMBOLS-1-k)*BYTE_W +: BYTE_W]
                                         : ast_sink_data_i[k*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        nsym = ast_sink_endofpacket_i ? AST_SINK_SYMBOLS - int'(ast_sink_empty_i) : AST_SINK_SYMBOLS;
        if (nsym < 0) begin
            nsym = 0;
        end
        base   = ast_sink_startofpacket_i ? 0 : int'(len_q);
        data_d = ast_sink_startofpacket_i ? '0 : data_q;
        err_d  = ast_sink_startofpacket_i ? (state_q == AST_RX_COLLECT) : err_q;
        // Constant-index double loop keeps the write pointer free of variable part-selects.
        for (int j = 0; j < DATA_SYMBOLS; j++) begin
            for (int k = 0; k < AST_SINK_SYMBOLS; k++) begin
                if ((k < nsym) && (base + k == j)) begin
                    data_d[j*BYTE_W +: BYTE_W] = beat_sym[k];
                end
            end
        end
        for (int k = 0; k < AST_SINK_SYMBOLS; k++) begin
            if ((k < nsym) && (base + k >= DATA_SYMBOLS)) begin
                err_d = 1'b1;
            end
        end
        total = base + nsym;
        if (total > DATA_SYMBOLS) begin
            total = DATA_SYMBOLS;
        end
        len_d = LEN_W'(total);
    end

    assign accept = ast_sink_valid_i && ready_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= AST_RX_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                AST_RX_IDLE, AST_RX_COLLECT: begin
                    if (accept && (ast_sink_startofpacket_i || (state_q == AST_RX_COLLECT))) begin
                        data_q <= data_d;
                        len_q  <= len_d;
                        err_q  <= err_d;
                        if (ast_sink_endofpacket_i) begin
                            state_q <= AST_RX_HOLD;
                            valid_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= AST_RX_COLLECT;
                        end
                    end
                end
                AST_RX_HOLD: begin
                    if (data_ready_i) begin
                        state_q <= AST_RX_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= AST_RX_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ast_sink_ready_o = ready_q;
    assign data_o           = data_q;
    assign data_len_o       = len_q;
    assign data_err_o       = err_q;
    assign data_valid_o     = valid_q;

endmodule

// File: tb/tb_ast_to_data.sv
// tb/tb_ast_to_data.sv - directed and random loopback bench for ast_to_data
module tb_ast_to_data;

    localparam int SYMS [3] = '{1, 4, 6};
    localparam int ORD  [3] = '{1, 1, 0};

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    logic [47:0] s_data   [3];
    logic [2:0]  s_empty  [3];
    logic        s_valid  [3];
    logic        s_sop    [3];
    logic        s_eop    [3];
    logic        s_dready [3];

    logic [47:0] dout   [4];
    logic [2:0]  len    [4];
    logic        err    [4];
    logic        dvalid [4];
    logic        rdy    [4];

    logic [31:0] c_data;
    assign c_data = {s_data[1][7:0], s_data[1][15:8], s_data[1][23:16], s_data[1][31:24]};

    int n_assert = 0;
    int n_fail   = 0;

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1'b1)) u_a (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(s_data[0][7:0]), .ast_sink_valid_i(s_valid[0]), .ast_sink_ready_o(rdy[0]),
        .ast_sink_empty_i(s_empty[0][0:0]), .ast_sink_startofpacket_i(s_sop[0]),
        .ast_sink_endofpacket_i(s_eop[0]), .data_o(dout[0]), .data_len_o(len[0]),
        .data_err_o(err[0]), .data_valid_o(dvalid[0]), .data_ready_i(s_dready[0]));

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1'b1)) u_b (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(s_data[1][31:0]), .ast_sink_valid_i(s_valid[1]), .ast_sink_ready_o(rdy[1]),
        .ast_sink_empty_i(s_empty[1][1:0]), .ast_sink_startofpacket_i(s_sop[1]),
        .ast_sink_endofpacket_i(s_eop[1]), .data_o(dout[1]), .data_len_o(len[1]),
        .data_err_o(err[1]), .data_valid_o(dvalid[1]), .data_ready_i(s_dready[1]));

    // Little-endian twin of u_b fed with lane-reversed data: same arrival order, same result.
    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1'b0)) u_c (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(c_data), .ast_sink_valid_i(s_valid[1]), .ast_sink_ready_o(rdy[3]),
        .ast_sink_empty_i(s_empty[1][1:0]), .ast_sink_startofpacket_i(s_sop[1]),
        .ast_sink_endofpacket_i(s_eop[1]), .data_o(dout[3]), .data_len_o(len[3]),
        .data_err_o(err[3]), .data_valid_o(dvalid[3]), .data_ready_i(s_dready[1]));

    ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(6), .AST_SINK_ORDER(1'b0)) u_d (
        .clk_i(clk), .srst_i(srst),
        .ast_sink_data_i(s_data[2]), .ast_sink_valid_i(s_valid[2]), .ast_sink_ready_o(rdy[2]),
        .ast_sink_empty_i(s_empty[2]), .ast_sink_startofpacket_i(s_sop[2]),
        .ast_sink_endofpacket_i(s_eop[2]), .data_o(dout[2]), .data_len_o(len[2]),
        .data_err_o(err[2]), .data_valid_o(dvalid[2]), .data_ready_i(s_dready[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input int o, input string tag, input logic [47:0] w, input int l,
                           input bit e, input bit v);
        chk({tag, " data"}, 64'(dout[o]), 64'(w));
        chk({tag, " len"}, 64'(len[o]), 64'(l));
        chk({tag, " err"}, 64'(err[o]), 64'(e));
        chk({tag, " valid"}, 64'(dvalid[o]), 64'(v));
        chk({tag, " sink_ready"}, 64'(rdy[o]), 64'(!v));
    endtask

    task automatic chk_unit(input int u, input string tag, input logic [47:0] w, input int l,
                            input bit e, input bit v);
        chk_out(u, tag, w, l, e, v);
        if (u == 1) chk_out(3, {tag, " le"}, w, l, e, v);
    endtask

    // Reference: the first six symbols in arrival order, low byte first.
    task automatic model(input logic [7:0] s[$], output logic [47:0] w, output int l, output bit e);
        w = '0;
        l = (s.size() > 6) ? 6 : s.size();
        e = (s.size() > 6);
        for (int i = 0; i < l; i++) w[i*8 +: 8] = s[i];
    endtask

    task automatic beat(input int u, input logic [47:0] d, input int emp, input bit sop, input bit eop);
        s_data[u]  = d;
        s_empty[u] = 3'(emp);
        s_sop[u]   = sop;
        s_eop[u]   = eop;
        s_valid[u] = 1'b1;
        @(posedge clk); #1;
        s_valid[u] = 1'b0;
        s_sop[u]   = 1'b0;
        s_eop[u]   = 1'b0;
    endtask

    task automatic send_pkt(input int u, input logic [7:0] syms[$], input bit gaps);
        int s, n, nb, cnt, lane, emp;
        logic [47:0] d;
        s  = SYMS[u];
        n  = syms.size();
        nb = (n + s - 1) / s;
        for (int b = 0; b < nb; b++) begin
            cnt = (n - b*s < s) ? n - b*s : s;
            d = {$urandom, $urandom};
            for (int k = 0; k < cnt; k++) begin
                lane = ORD[u] ? s - 1 - k : k;
                d[lane*8 +: 8] = syms[b*s + k];
            end
            emp = (b == nb - 1) ? s - cnt : $urandom_range(0, s - 1);
            chk("sink_ready before beat", 64'(rdy[u]), 64'(1));
            beat(u, d, emp, b == 0, b == nb - 1);
            if (gaps && b != nb - 1 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic take(input int u, input logic [47:0] w, input int l, input bit e, input int waits);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
            chk_unit(u, "hold", w, l, e, 1'b1);
        end
        s_dready[u] = 1'b1;
        @(posedge clk); #1;
        s_dready[u] = 1'b0;
        chk_unit(u, "release", w, l, e, 1'b0);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [47:0] w;
        int          l;
        bit          e;

        for (int i = 0; i < 3; i++) begin
            s_data[i] = '0; s_empty[i] = '0; s_valid[i] = 1'b0;
            s_sop[i] = 1'b0; s_eop[i] = 1'b0; s_dready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        for (int u = 0; u < 3; u++) chk_unit(u, "reset", 48'h0, 0, 1'b0, 1'b0);

        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt(0, q, 1'b0);
        chk_unit(0, "be1", 48'h665544332211, 6, 1'b0, 1'b1);
        take(0, 48'h665544332211, 6, 1'b0, 5);

        beat(1, 48'h11223344, 0, 1'b1, 1'b0);
        beat(1, 48'h5566a5a5, 2, 1'b0, 1'b1);
        chk_unit(1, "be4", 48'h665544332211, 6, 1'b0, 1'b1);
        take(1, 48'h665544332211, 6, 1'b0, 0);

        q = {8'h11, 8'h22, 8'h33};
        send_pkt(0, q, 1'b0);
        chk_unit(0, "short", 48'h000000332211, 3, 1'b0, 1'b1);
        take(0, 48'h000000332211, 3, 1'b0, 1);

        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_pkt(0, q, 1'b0);
        chk_unit(0, "long", 48'h665544332211, 6, 1'b1, 1'b1);
        take(0, 48'h665544332211, 6, 1'b1, 0);

        beat(0, 48'h77, 0, 1'b0, 1'b0);
        chk_unit(0, "idle_nosop", 48'h665544332211, 6, 1'b1, 1'b0);
        q = {8'haa, 8'hbb};
        send_pkt(0, q, 1'b0);
        chk_unit(0, "after_nosop", 48'h00000000bbaa, 2, 1'b0, 1'b1);
        take(0, 48'h00000000bbaa, 2, 1'b0, 0);

        beat(0, 48'h11, 0, 1'b1, 1'b0);
        beat(0, 48'h22, 0, 1'b0, 1'b0);
        beat(0, 48'h44, 0, 1'b1, 1'b0);
        beat(0, 48'h55, 0, 1'b0, 1'b1);
        chk_unit(0, "restart", 48'h000000005544, 2, 1'b1, 1'b1);
        take(0, 48'h000000005544, 2, 1'b1, 0);

        beat(1, 48'h11223344, 0, 1'b1, 1'b0);
        beat(1, 48'haabbccdd, 1, 1'b1, 1'b1);
        chk_unit(1, "restart_eop", 48'h000000ccbbaa, 3, 1'b1, 1'b1);
        take(1, 48'h000000ccbbaa, 3, 1'b1, 0);

        beat(0, 48'h11, 0, 1'b1, 1'b0);
        beat(0, 48'h22, 0, 1'b0, 1'b0);
        s_data[0] = 48'h33; s_valid[0] = 1'b1; srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0; s_valid[0] = 1'b0;
        chk_unit(0, "srst_mid", 48'h0, 0, 1'b0, 1'b0);
        q = {8'ha1, 8'hb2, 8'hc3, 8'hd4, 8'he5, 8'hf6};
        send_pkt(0, q, 1'b0);
        chk_unit(0, "after_srst", 48'hf6e5d4c3b2a1, 6, 1'b0, 1'b1);
        take(0, 48'hf6e5d4c3b2a1, 6, 1'b0, 0);

        send_pkt(2, q, 1'b0);
        chk_unit(2, "be6", 48'hf6e5d4c3b2a1, 6, 1'b0, 1'b1);
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        chk_unit(2, "srst_hold", 48'h0, 0, 1'b0, 1'b0);

        for (int it = 0; it < 1000; it++) begin
            for (int u = 0; u < 3; u++) begin
                q = {};
                for (int i = 0; i < $urandom_range(1, 8); i++) q.push_back(8'($urandom));
                model(q, w, l, e);
                send_pkt(u, q, 1'b1);
                chk_unit(u, "loop", w, l, e, 1'b1);
                take(u, w, l, e, $urandom_range(0, 3));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ast_to_data.md
# ast_to_data

Avalon-ST sink that collects one packet of `BYTE_W`-bit symbols into a single `DATA_SYMBOLS`-wide word. It presents that word on a valid/ready handshake. It is the receive-side counterpart of the word-to-stream sender: it rebuilds search strings and keys from stream input before they go to the bloom-filter hash stages. A loopback of sender → `ast_to_data` with matching parameters must return the original word unchanged.

## Interface
- `BYTE_W`, default 8: symbol width in bits.
- `DATA_SYMBOLS`, default 6: symbols in the output word.
- `AST_SINK_SYMBOLS`, default 1: symbols per Avalon-ST beat.
- `AST_SINK_ORDER`, default 1'b1: 1 means the earliest symbol of a beat is on the highest lane (big-endian); 0 means it is on lane 0.
- `AST_SINK_EMPTY_W`, default 1 if `AST_SINK_SYMBOLS`==1, else `$clog2(AST_SINK_SYMBOLS)`.
- `clk_i`  in  1  single clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `ast_sink_data_i`  in  `AST_SINK_SYMBOLS`×`BYTE_W`  beat data.
- `ast_sink_valid_i`  in  1  beat valid.
- `ast_sink_ready_o`  out  1  beat accepted when valid&&ready.
- `ast_sink_empty_i`  in  `AST_SINK_EMPTY_W`  unused symbols; only meaningful on the EOP beat.
- `ast_sink_startofpacket_i`  in  1  first beat of the packet.
- `ast_sink_endofpacket_i`  in  1  last beat of the packet.
- `data_o`  out  `DATA_SYMBOLS`×`BYTE_W`  assembled word; symbol 0 is the first received and sits in the low byte.
- `data_len_o`  out  `$clog2(DATA_SYMBOLS+1)`  number of symbols stored, saturating at `DATA_SYMBOLS`.
- `data_err_o`  out  1  packet overflowed, or was restarted by an early SOP.
- `data_valid_o`  out  1  word available.
- `data_ready_i`  in  1  downstream takes the word when valid&&ready.

## Operation
- FSM states: IDLE, COLLECT, HOLD.
- **IDLE**
  - Beat accepted with SOP: clear the word, length and error; store the beat.
  - If that beat also has EOP, go to HOLD; otherwise go to COLLECT.
  - Beats accepted without SOP are discarded silently.
- **COLLECT**
  - Store each accepted beat at the write pointer. The pointer equals `data_len_o`.
  - An EOP beat goes to HOLD.
  - A SOP beat (with or without EOP) discards the partial word and restarts as described for IDLE. The error bit of the new packet is set.
- **HOLD**
  - `data_valid_o`=1.
  - When `data_ready_i`=1, go to IDLE.
- Beat symbol count:
  - `AST_SINK_SYMBOLS` on non-EOP beats.
  - `AST_SINK_SYMBOLS - empty` on the EOP beat.
  - Valid symbols are the first in arrival order.
- Lane mapping:
  - ORDER=1: lane `AST_SINK_SYMBOLS-1-k` goes to word symbol ptr+k.
  - ORDER=0: lane k goes to word symbol ptr+k.
- Overflow: symbols at index ≥ `DATA_SYMBOLS` are dropped and `data_err_o` is set. Length saturates at `DATA_SYMBOLS`; the pointer arithmetic must not wrap.
- Short packet: symbols not written stay 0, because the word is cleared at SOP.
- `data_o`, `data_len_o` and `data_err_o` are stable throughout HOLD and keep their values after the handshake until the next SOP.

## Timing
- `ast_sink_ready_o` = !HOLD; it is registered from state.
- In IDLE and COLLECT it is 1 every cycle, so there is no sink backpressure while collecting.
- `data_valid_o` rises the cycle after the EOP beat is accepted, so latency from the EOP beat is 1 cycle.
- The handshake cycle (`data_valid_o`&&`data_ready_i`) ends HOLD. The next cycle is IDLE with ready=1.
- Minimum packet period is beats+1 cycles when the downstream is always ready.
- Reset values: state IDLE, `data_o`=0, `data_len_o`=0, `data_err_o`=0, `data_valid_o`=0, `ast_sink_ready_o`=1 from the first cycle after reset.
- `srst_i` mid-packet or in HOLD drops everything, including a pending word.
- `ast_sink_empty_i` is ignored on non-EOP beats.

## Structure
- Shared package (`ast_pkg`):
  - state enum `ast_rx_state_t`;
  - function `ast_empty_w(symbols)` used by both this block and the sender;
  - width helper for the length field.
- A single module is sufficient.
- Lane reordering is a local `always_comb` loop. No sub-module is needed.

## Test plan
- **Single-symbol beats, big-endian.** Parameters 8/6/1/1. Send 0x11,0x22,0x33,0x44,0x55,0x66 with SOP on the first and EOP on the last → `data_o`=0x665544332211, len 6, err 0, valid one cycle after the EOP beat.
- **Four-symbol beats, big-endian.** Parameters 8/6/4/1. Beat 1 lanes[3:0]=11 22 33 44, empty 0. Beat 2 lanes[3:2]=55 66 with EOP, empty 2 → `data_o`=0x665544332211.
- **Short packet.** Parameters 8/6/1/1. Send 3 bytes 0x11,0x22,0x33 → `data_o`=0x000000332211, len 3, err 0.
- **Long packet.** Send 8 bytes 0x11..0x88 → `data_o`=0x665544332211, len 6, err 1.
- **Backpressure and restart.**
  - Hold `data_ready_i`=0 for 5 cycles → outputs stable, `ast_sink_ready_o`=0; the first cycle with ready=1 completes the handshake.
  - SOP arriving mid-packet → the new packet is stored and err=1.
  - A beat without SOP while in IDLE is ignored.
- **Reset and loopback.**
  - Assert `srst_i` during beat 3 → all outputs return to 0 and ready=1; the next full packet is received correctly.
  - 1000 random words through the sender → `ast_to_data` (ORDER 0 and 1; 1, 4 and 6 symbols per beat) → every word matches.
